// File: rtl/money_collect.sv
`default_nettype none
// ============================================================================
// money_collect: coin accumulation, price check and 50/10/1 change payout.
// Rev 1.0
// ============================================================================
module money_collect #(
  parameter int MONEY_MAX = 200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       coin_valid,
  input  logic [1:0] coin_den,
  output logic       coin_ready,
  output logic       coin_reject,
  input  logic [1:0] ticketType,
  input  logic [1:0] ticketCount,
  input  logic       confirm,
  input  logic       cancel,
  output logic [7:0] money,
  output logic [7:0] moneyReturn,
  output logic       ticket_out,
  output logic       err_insufficient,
  output logic       change_valid,
  output logic [1:0] change_den,
  input  logic       change_ack,
  output logic       done
);

  typedef enum logic [1:0] {
    ST_COLLECT  = 2'd0,
    ST_CHECK    = 2'd1,
    ST_DISPENSE = 2'd2,
    ST_DONE     = 2'd3
  } state_t;

  localparam logic [8:0] c_money_max = 9'(MONEY_MAX);

  function automatic logic [7:0] den_value(input logic [1:0] den);
    case (den)
      2'b00:   den_value = 8'd1;
      2'b01:   den_value = 8'd10;
      2'b10:   den_value = 8'd50;
      default: den_value = 8'd0;
    endcase
  endfunction

  function automatic logic [1:0] pick_den(input logic [7:0] amt);
    if (amt >= 8'd50)      pick_den = 2'b10;
    else if (amt >= 8'd10) pick_den = 2'b01;
    else                   pick_den = 2'b00;
  endfunction

  state_t     state_q;
  logic [7:0] money_q;
  logic [7:0] ret_q;
  logic [7:0] rem_q;
  logic       ret_clear_q;
  logic       coin_ready_q;
  logic       coin_reject_q;
  logic       ticket_q;
  logic       err_q;
  logic       change_valid_q;
  logic [1:0] change_den_q;
  logic       done_q;

  logic       coin_take;
  logic       coin_fits;
  logic [8:0] coin_sum;
  logic [7:0] money_d;
  logic [3:0] price;
  logic       price_ok;
  logic [7:0] change_d;
  logic [7:0] rem_d;

  always_comb begin
    coin_take = coin_valid & coin_ready_q & (state_q == ST_COLLECT);
    coin_sum  = {1'b0, money_q} + {1'b0, den_value(coin_den)};
    coin_fits = (coin_den != 2'b11) && (coin_sum <= c_money_max);
    money_d   = (coin_take && coin_fits) ? coin_sum[7:0] : money_q;
    price     = {2'b00, ticketType} * {2'b00, ticketCount};
    price_ok  = (price != 4'd0) && (money_q >= {4'b0000, price});
    change_d  = money_q - {4'b0000, price};
    rem_d     = rem_q - den_value(change_den_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ST_COLLECT;
      money_q        <= 8'd0;
      ret_q          <= 8'd0;
      rem_q          <= 8'd0;
      ret_clear_q    <= 1'b0;
      coin_ready_q   <= 1'b0;
      coin_reject_q  <= 1'b0;
      ticket_q       <= 1'b0;
      err_q          <= 1'b0;
      change_valid_q <= 1'b0;
      change_den_q   <= 2'b00;
      done_q         <= 1'b0;
    end else begin
      coin_reject_q <= 1'b0;
      ticket_q      <= 1'b0;
      err_q         <= 1'b0;
      done_q        <= 1'b0;
      case (state_q)
        ST_COLLECT: begin
          money_q <= money_d;
          if (coin_take) begin
            coin_reject_q <= ~coin_fits;
            // moneyReturn from the previous transaction stays visible until new money arrives
            if (coin_fits && ret_clear_q) begin
              ret_q       <= 8'd0;
              ret_clear_q <= 1'b0;
            end
          end
          if (cancel) begin
            ret_q        <= money_d;
            rem_q        <= money_d;
            ret_clear_q  <= 1'b0;
            coin_ready_q <= 1'b0;
            if (money_d == 8'd0) begin
              state_q <= ST_DONE;
            end else begin
              state_q        <= ST_DISPENSE;
              change_valid_q <= 1'b1;
              change_den_q   <= pick_den(money_d);
            end
          end else if (confirm) begin
            state_q      <= ST_CHECK;
            coin_ready_q <= 1'b0;
          end else begin
            coin_ready_q <= 1'b1;
          end
        end

        ST_CHECK: begin
          if (price_ok) begin
            ticket_q    <= 1'b1;
            ret_q       <= change_d;
            rem_q       <= change_d;
            ret_clear_q <= 1'b0;
            if (change_d == 8'd0) begin
              state_q <= ST_DONE;
            end else begin
              state_q        <= ST_DISPENSE;
              change_valid_q <= 1'b1;
              change_den_q   <= pick_den(change_d);
            end
          end else begin
            err_q        <= 1'b1;
            state_q      <= ST_COLLECT;
            coin_ready_q <= 1'b1;
          end
        end

        ST_DISPENSE: begin
          if (change_valid_q && change_ack) begin
            rem_q <= rem_d;
            if (rem_d == 8'd0) begin
              change_valid_q <= 1'b0;
              state_q        <= ST_DONE;
            end else begin
              change_den_q <= pick_den(rem_d);
            end
          end
        end

        ST_DONE: begin
          done_q       <= 1'b1;
          money_q      <= 8'd0;
          ret_clear_q  <= 1'b1;
          coin_ready_q <= 1'b1;
          state_q      <= ST_COLLECT;
        end

        default: begin
          state_q <= ST_COLLECT;
        end
      endcase
    end
  end

  assign coin_ready       = coin_ready_q;
  assign coin_reject      = coin_reject_q;
  assign money            = money_q;
  assign moneyReturn      = ret_q;
  assign ticket_out       = ticket_q;
  assign err_insufficient = err_q;
  assign change_valid     = change_valid_q;
  assign change_den       = change_den_q;
  assign done             = done_q;

endmodule
`default_nettype wire

// File: doc/money_collect.md
Name: money_collect

Overview:
- Front end of the ticket vending datapath. Accepts coin/note insertions one at a time and accumulates the inserted total in `money`.
- On confirm, checks the total against price = ticketType × ticketCount and issues the ticket, or flags insufficient funds.
- Pays out change (or a full refund on cancel) as a serial stream of 50/10/1 denomination tokens over a valid/ack handshake.
- Its `money` and `moneyReturn` outputs feed the display digit scanner.

Parameters:
- MONEY_MAX, 200, ceiling on accumulated `money`. An insertion that would exceed it is rejected.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- coin_valid  in  1  insertion present this cycle
- coin_den  in  2  insertion value: 00=1, 01=10, 10=50, 11=illegal
- coin_ready  out  1  block accepts an insertion this cycle
- coin_reject  out  1  one-cycle pulse: insertion refused (illegal denomination or over MONEY_MAX)
- ticketType  in  2  unit price 0..3
- ticketCount  in  2  ticket quantity 0..3
- confirm  in  1  purchase request, level-sampled
- cancel  in  1  refund request, level-sampled
- money  out  8  accumulated inserted total
- moneyReturn  out  8  change/refund amount of the last transaction
- ticket_out  out  1  one-cycle pulse: ticket issued
- err_insufficient  out  1  one-cycle pulse: price 0 or money < price
- change_valid  out  1  change token offered
- change_den  out  2  offered token: 00=1, 01=10, 10=50
- change_ack  in  1  dispenser took the token
- done  out  1  one-cycle pulse: transaction closed

Behaviour:
- Reset (rst=0, asynchronous): state=COLLECT, money=0, moneyReturn=0, rem=0. All pulses, coin_ready and change_valid are 0.
- After reset release, coin_ready=1 from the first clock edge.
- States: COLLECT, CHECK, DISPENSE, DONE.
- COLLECT:
  - coin_ready=1. An insertion is accepted on coin_valid & coin_ready at the clock edge.
  - Legal denomination and money+value ≤ MONEY_MAX: money += value on that edge.
  - Otherwise: coin_reject pulses the next cycle and money is unchanged.
  - First insertion accepted after DONE clears moneyReturn to 0.
  - cancel=1: moneyReturn←money, rem←money, go to DISPENSE (DONE if money=0). cancel beats confirm in the same cycle.
  - confirm=1 (cancel=0): go to CHECK.
  - An insertion accepted in the same cycle as confirm/cancel is included in money first.
- CHECK (one cycle, coin_ready=0):
  - price = ticketType*ticketCount, 4-bit unsigned, max 9.
  - price=0 or money<price: err_insufficient pulse, money kept, return to COLLECT.
  - Otherwise: ticket_out pulse, moneyReturn←money−price, rem←money−price, go to DISPENSE (DONE if the difference is 0).
  - Latency from confirm sampled to ticket_out: 2 cycles (confirm edge → CHECK, CHECK edge → pulse registered).
- DISPENSE (coin_ready=0, insertions ignored without reject):
  - change_valid=1.
  - change_den = 50 if rem≥50, else 10 if rem≥10, else 1.
  - On change_valid & change_ack: rem -= token value. The next token is presented the following cycle, so back-to-back acks give one token per cycle.
  - change_den is stable while valid and not acked.
  - When the acked token makes rem 0: change_valid=0 next cycle, go to DONE.
  - Token sequence equals the 50/10/1 decomposition of moneyReturn, largest first.
- DONE (one cycle): done pulse, money←0, moneyReturn held, return to COLLECT.
- cancel and confirm are ignored outside COLLECT. change_ack is ignored when change_valid=0.
- Reset mid-DISPENSE discards the remaining rem. No recovery is required.
- All outputs are registered and all pulses are exactly one cycle wide.

Test Plan:
- Insert 50,10,1,1 then confirm with ticketType=3, ticketCount=3 → money=62; ticket_out 2 cycles after confirm; moneyReturn=53; tokens 50,1,1,1 with ack held high; done; money=0.
- Insert 10, confirm with type=3, count=3 → no error, moneyReturn=1, single token 1. Then insert 1, confirm with type=2, count=3 → err_insufficient pulse, money stays 1, remains in COLLECT.
- Insert 50×4 (money=200), then 1 → coin_reject pulse, money=200. coin_den=11 → coin_reject, money unchanged.
- money=67, cancel and confirm asserted together → no ticket_out; tokens 50,10,1×7 (9 transfers); moneyReturn=67.
- Dispense 50,10 with change_ack low for 5 cycles between tokens → change_valid/den held at 10 until ack; exactly 2 transfers.
- Assert rst low mid-DISPENSE → all outputs 0 immediately (asynchronous); after release, coin_ready=1 and a new insertion is accepted normally.
